dsn_res_rd: RTL and testbench

Result-RAM reader for the key-generation datapath. It runs once the polynomial multiply controller has finished writing the product into the result RAM. The block reads all `G_DAT_DEP` words through one BRAM read port and streams them out over a valid/ready interface. While streaming it zeroes the pad bits of the final word and accumulates the Hamming weight of the `r`-bit result.

---
 rtl/dsn_res_rd_pkg.sv | 28 ++
 rtl/blk_popcnt.sv | 31 +++
 rtl/dsn_res_rd.sv | 134 +++++++++++++
 tb/tb_dsn_res_rd.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsn_res_rd_pkg.sv
// Shared constants, derived widths and FSM encoding for the result-RAM reader.
package dsn_res_rd_pkg;

    localparam int R_BITS  = 10163;
    localparam int ADDR_W  = 8;
    localparam int DAT_W   = 64;
    localparam int DAT_DEP = 159;
    localparam int WGT_W   = 14;

    function automatic int pad_bits(input int r, input int w, input int dep);
        return dep * w - r;
    endfunction

    function automatic bit wgt_w_ok(input int r, input int h);
        return (2 ** h) > r;
    endfunction

    localparam int PAD      = pad_bits(R_BITS, DAT_W, DAT_DEP);
    localparam bit WGT_W_OK = wgt_w_ok(R_BITS, WGT_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/blk_popcnt.sv
// Combinational 64-bit population count built as a balanced adder tree.
module blk_popcnt (
    input  logic [63:0] din,
    output logic [6:0]  cnt
);

    logic [1:0] l1 [32];
    logic [2:0] l2 [16];
    logic [3:0] l3 [8];
    logic [4:0] l4 [4];
    logic [5:0] l5 [2];

    for (genvar i = 0; i < 32; i++) begin : g_l1
        assign l1[i] = 2'(din[2*i]) + 2'(din[2*i+1]);
    end
    for (genvar i = 0; i < 16; i++) begin : g_l2
        assign l2[i] = 3'(l1[2*i]) + 3'(l1[2*i+1]);
    end
    for (genvar i = 0; i < 8; i++) begin : g_l3
        assign l3[i] = 4'(l2[2*i]) + 4'(l2[2*i+1]);
    end
    for (genvar i = 0; i < 4; i++) begin : g_l4
        assign l4[i] = 5'(l3[2*i]) + 5'(l3[2*i+1]);
    end
    for (genvar i = 0; i < 2; i++) begin : g_l5
        assign l5[i] = 6'(l4[2*i]) + 6'(l4[2*i+1]);
    end

    assign cnt = 7'(l5[0]) + 7'(l5[1]);

endmodule

// File: rtl/dsn_res_rd.sv
// Result-RAM reader: streams every RAM word with pad bits cleared
// and accumulates the Hamming weight of the r-bit result.
module dsn_res_rd
    import dsn_res_rd_pkg::*;
#(
    parameter int r         = R_BITS,
    parameter int G_ADDR_W  = ADDR_W,
    parameter int G_DAT_W   = DAT_W,
    parameter int G_DAT_DEP = DAT_DEP,
    parameter int H_DAT_W   = WGT_W
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [G_ADDR_W-1:0] re_addr,
    output logic                re_en,
    input  logic [G_DAT_W-1:0]  re_din,
    output logic [G_DAT_W-1:0]  m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic [H_DAT_W-1:0]  weight
);

    localparam int PAD_W = pad_bits(r, G_DAT_W, G_DAT_DEP);
    localparam logic [G_DAT_W-1:0] LAST_MASK =
        ~((G_DAT_W'(1) << PAD_W) - G_DAT_W'(1));
    localparam logic [G_ADDR_W-1:0] LAST_ADDR = G_ADDR_W'(G_DAT_DEP - 1);

    if (!wgt_w_ok(r, H_DAT_W)) begin : g_wgt_chk
        $error("H_DAT_W too narrow for r");
    end

    state_t state, state_nxt;

    logic [1:0]         fifo_cnt;
    logic               rd_ptr;
    logic               wr_ptr;
    logic [G_DAT_W-1:0] fifo_d [2];
    logic               fifo_l [2];
    logic               inflight;
    logic               infl_last;
    logic               pop;
    logic               issue;
    logic               start_acc;
    logic [2:0]         occ;
    logic [6:0]         pc;

    assign start_acc = (state == ST_IDLE) && start;
    assign pop       = m_valid && m_ready;
    // Slots already claimed once this cycle's pop retires.
    assign occ       = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    assign wr_ptr    = rd_ptr ^ fifo_cnt[0];

    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_d[rd_ptr];
    assign m_last  = fifo_l[rd_ptr];

    blk_popcnt u_popcnt (
        .din (m_data),
        .cnt (pc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (issue && re_addr == LAST_ADDR) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pop && m_last) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        issue = 1'b0;
        unique case (state)
            ST_RUN: begin
                busy  = 1'b1;
                issue = (occ < 3'd2);
            end
            ST_DRAIN: busy = 1'b1;
            ST_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    assign re_en = issue;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            re_addr <= '0;
            weight  <= '0;
        end else begin
            if (start_acc)  re_addr <= '0;
            else if (issue) re_addr <= re_addr + G_ADDR_W'(1);
            if (start_acc)  weight <= '0;
            else if (pop)   weight <= weight + H_DAT_W'(pc);
        end
    end

    // Pad bits are cleared on capture so head data and popcount agree.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fifo_cnt  <= '0;
            rd_ptr    <= 1'b0;
            fifo_d[0] <= '0;
            fifo_d[1] <= '0;
            fifo_l[0] <= 1'b0;
            fifo_l[1] <= 1'b0;
            inflight  <= 1'b0;
            infl_last <= 1'b0;
        end else begin
            inflight  <= issue;
            infl_last <= issue && (re_addr == LAST_ADDR);
            if (inflight) begin
                fifo_d[wr_ptr] <= infl_last ? (re_din & LAST_MASK) : re_din;
                fifo_l[wr_ptr] <= infl_last;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_dsn_res_rd.sv
// Self-checking bench for dsn_res_rd: RAM model, stream collector
// and a list-level reference of the expected words and weight.
module tb_dsn_res_rd;

    localparam int DEP = 159;
    localparam int DW  = 64;
    localparam int AW  = 8;
    localparam int HW  = 14;
    localparam int RB  = 10163;
    localparam int PAD = DEP * DW - RB;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] re_din = '0;
    logic          busy, done, re_en, m_valid, m_last;
    logic [AW-1:0] re_addr;
    logic [DW-1:0] m_data;
    logic [HW-1:0] weight;

    always #5 clk = ~clk;

    dsn_res_rd dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .re_addr (re_addr),
        .re_en   (re_en),
        .re_din  (re_din),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .weight  (weight)
    );

    logic [DW-1:0] ram [DEP];

    always @(posedge clk)
        if (re_en && int'(re_addr) < DEP) re_din <= ram[re_addr];

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] got[$];
    int            last_pos[$];
    int  done_k, done_cnt, unstable, overissue, addr_err;
    int  busy_err, bubbles, timeout, first_v, stall_reads;
    logic [AW+1:0] first_snap;
    logic [HW-1:0] weight_done, weight_after;
    logic [90:0]   rst_snap;

    function automatic logic [DW-1:0] exp_word(input int i);
        logic [DW-1:0] w;
        w = ram[i];
        if (i == DEP - 1)
            for (int b = 0; b < PAD; b++) w[b] = 1'b0;
        return w;
    endfunction

    function automatic int exp_weight();
        int s = 0;
        for (int i = 0; i < DEP; i++) s += $countones(exp_word(i));
        return s;
    endfunction

    function automatic int stream_errs();
        int e;
        e = (got.size() > DEP) ? got.size() - DEP : DEP - got.size();
        for (int i = 0; i < DEP && i < got.size(); i++)
            if (got[i] !== exp_word(i)) e++;
        return e;
    endfunction

    function automatic bit last_ok();
        return last_pos.size() == 1 && last_pos[0] == DEP - 1;
    endfunction

    // rmode: 0 ready high, 1 random 30%, 2 held low 50 cycles after first valid
    task automatic drive_run(input int rmode, input int repulse, input int abort_w);
        int issued = 0, popped = 0, k = 0, post = 0;
        bit stalled = 0, seen_done = 0, hs;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        got.delete();
        last_pos.delete();
        done_k = -1; done_cnt = 0; unstable = 0; overissue = 0;
        addr_err = 0; busy_err = 0; bubbles = 0; timeout = 0;
        first_v = -1; stall_reads = -1;
        @(negedge clk);
        start = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            k++;
            start = (k == repulse);
            case (rmode)
                1:       m_ready = ($urandom_range(99) < 30);
                2:       m_ready = (first_v >= 0 && k > first_v + 50);
                default: m_ready = 1'b1;
            endcase
            if (abort_w >= 0 && got.size() == abort_w) begin
                rst_b = 1'b0;
                #1;
                rst_snap = {busy, done, re_en, m_valid, m_last,
                            re_addr, m_data, weight};
                @(negedge clk);
                rst_b = 1'b1;
                start = 1'b0;
                m_ready = 1'b0;
                return;
            end
            #1;
            hs = m_valid && m_ready;
            if (k == 1) first_snap = {busy, re_en, re_addr};
            if (m_valid && first_v < 0) first_v = k;
            if (stalled && (!m_valid || m_data !== pd || m_last !== pl))
                unstable++;
            stalled = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            if (re_en) begin
                if (issued - popped - int'(hs) >= 2) overissue++;
                if (re_addr !== AW'(issued)) addr_err++;
                issued++;
            end
            if (rmode == 2 && k == first_v + 50) stall_reads = issued;
            if (first_v >= 0 && m_ready && !m_valid && got.size() < DEP)
                bubbles++;
            if (hs) begin
                got.push_back(m_data);
                if (m_last) last_pos.push_back(got.size() - 1);
                popped++;
            end
            if (!seen_done && !done && !busy) busy_err++;
            if (done && busy) busy_err++;
            if (done) begin
                done_cnt++;
                if (!seen_done) begin
                    done_k = k;
                    weight_done = weight;
                end
                seen_done = 1;
            end
            if (seen_done) begin
                post++;
                if (post > 6) break;
            end
            if (k > 4000) begin
                timeout = 1;
                break;
            end
        end
        weight_after = weight;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [90:0] v;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        v = {busy, done, re_en, m_valid, m_last, re_addr, m_data, weight};
        n_chk++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", v);
        end
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        v = {busy, done, re_en, m_valid, m_last, re_addr, m_data, weight};
        n_chk++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want 0", v);
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < DEP; i++) ram[i] = '1;
        drive_run(0, -1, -1);
        n_chk++;
        if (timeout !== 0) begin
            n_fail++;
            $display("FAIL ones_timeout: got %0d want 0", timeout);
        end
        n_chk++;
        if (first_snap !== {1'b1, 1'b1, AW'(0)}) begin
            n_fail++;
            $display("FAIL ones_first_cycle: got %h want %h",
                     first_snap, {1'b1, 1'b1, AW'(0)});
        end
        n_chk++;
        if (first_v !== 3) begin
            n_fail++;
            $display("FAIL ones_first_valid: got %0d want 3", first_v);
        end
        n_chk++;
        if (done_k !== DEP + 3) begin
            n_fail++;
            $display("FAIL ones_done_lat: got %0d want %0d", done_k, DEP + 3);
        end
        n_chk++;
        if (stream_errs() !== 0) begin
            n_fail++;
            $display("FAIL ones_stream: got %0d errors want 0", stream_errs());
        end
        n_chk++;
        if (got.size() != DEP || got[DEP-1] !== 64'hFFFF_FFFF_FFFF_E000) begin
            n_fail++;
            $display("FAIL ones_last_word: got %h want FFFFFFFFFFFFE000",
                     got.size() > 0 ? got[got.size()-1] : '0);
        end
        n_chk++;
        if (!last_ok()) begin
            n_fail++;
            $display("FAIL ones_m_last: got %0d marks want 1 at %0d",
                     last_pos.size(), DEP - 1);
        end
        n_chk++;
        if (weight_done !== HW'(RB)) begin
            n_fail++;
            $display("FAIL ones_weight: got %0d want %0d", weight_done, RB);
        end
        n_chk++;
        if (bubbles !== 0 || busy_err !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL ones_flow: got bub=%0d busy=%0d done=%0d want 0/0/1",
                     bubbles, busy_err, done_cnt);
        end
        n_chk++;
        if (weight_after !== weight_done) begin
            n_fail++;
            $display("FAIL ones_weight_hold: got %0d want %0d",
                     weight_after, weight_done);
        end
    endtask

    task automatic test_addr_pattern();
        for (int i = 0; i < DEP; i++) ram[i] = DW'(i);
        ram[DEP-1] = '1;
        drive_run(0, -1, -1);
        n_chk++;
        if (stream_errs() !== 0 || !last_ok()) begin
            n_fail++;
            $display("FAIL addr_stream: got %0d errors want 0", stream_errs());
        end
        n_chk++;
        if (int'(weight_done) !== exp_weight()) begin
            n_fail++;
            $display("FAIL addr_weight: got %0d want %0d",
                     weight_done, exp_weight());
        end
        n_chk++;
        if (addr_err !== 0) begin
            n_fail++;
            $display("FAIL addr_seq: got %0d errors want 0", addr_err);
        end
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < DEP; i++) ram[i] = {$urandom, $urandom};
        drive_run(1, -1, -1);
        n_chk++;
        if (timeout !== 0 || stream_errs() !== 0 || !last_ok()) begin
            n_fail++;
            $display("FAIL rnd_stream: got %0d errors to=%0d want 0",
                     stream_errs(), timeout);
        end
        n_chk++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL rnd_stall_stable: got %0d want 0", unstable);
        end
        n_chk++;
        if (overissue !== 0 || addr_err !== 0) begin
            n_fail++;
            $display("FAIL rnd_issue: got over=%0d addr=%0d want 0/0",
                     overissue, addr_err);
        end
        n_chk++;
        if (int'(weight_done) !== exp_weight() || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL rnd_weight: got %0d want %0d",
                     weight_done, exp_weight());
        end
    endtask

    task automatic test_long_stall();
        for (int i = 0; i < DEP; i++) ram[i] = {$urandom, $urandom};
        drive_run(2, -1, -1);
        n_chk++;
        if (stall_reads < 0 || stall_reads > 2) begin
            n_fail++;
            $display("FAIL stall_reads: got %0d want <=2", stall_reads);
        end
        n_chk++;
        if (bubbles !== 0 || unstable !== 0) begin
            n_fail++;
            $display("FAIL stall_resume: got bub=%0d unst=%0d want 0/0",
                     bubbles, unstable);
        end
        n_chk++;
        if (stream_errs() !== 0 || int'(weight_done) !== exp_weight()) begin
            n_fail++;
            $display("FAIL stall_result: got err=%0d w=%0d want 0/%0d",
                     stream_errs(), weight_done, exp_weight());
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < DEP; i++) ram[i] = {$urandom, $urandom};
        drive_run(0, -1, 80);
        n_chk++;
        if (rst_snap !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0", rst_snap);
        end
        for (int i = 0; i < DEP; i++) ram[i] = {$urandom, $urandom};
        drive_run(0, -1, -1);
        n_chk++;
        if (addr_err !== 0 || done_k !== DEP + 3) begin
            n_fail++;
            $display("FAIL midrst_rerun: got addr=%0d lat=%0d want 0/%0d",
                     addr_err, done_k, DEP + 3);
        end
        n_chk++;
        if (stream_errs() !== 0 || int'(weight_done) !== exp_weight()) begin
            n_fail++;
            $display("FAIL midrst_result: got err=%0d w=%0d want 0/%0d",
                     stream_errs(), weight_done, exp_weight());
        end
    endtask

    task automatic test_restart_busy();
        for (int i = 0; i < DEP; i++) ram[i] = {$urandom, $urandom};
        drive_run(0, 40, -1);
        n_chk++;
        if (done_cnt !== 1 || done_k !== DEP + 3) begin
            n_fail++;
            $display("FAIL rest_done: got cnt=%0d lat=%0d want 1/%0d",
                     done_cnt, done_k, DEP + 3);
        end
        n_chk++;
        if (stream_errs() !== 0 || int'(weight_done) !== exp_weight()) begin
            n_fail++;
            $display("FAIL rest_result: got err=%0d w=%0d want 0/%0d",
                     stream_errs(), weight_done, exp_weight());
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_addr_pattern();
        test_random_ready();
        test_long_stall();
        test_reset_midrun();
        test_restart_busy();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
